// File: rtl/shab90_4096x16x1cm16.sv
// Single-port 4096x16 synchronous SRAM with a registered read port and write-through.
// DO is the output register gated to zero combinationally by OE.
module shab90_4096x16x1cm16 #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4096
) (
  input  logic              CK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] DI,
  output logic [DATA_W-1:0] DO,
  input  logic              WEB,
  input  logic              OE,
  input  logic              CS
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] dout_q;

  // Array has no reset; a write landing on a reset edge is dropped.
  always_ff @(posedge CK) begin
    if (!RST && CS && !WEB)
      mem[A] <= DI;
  end

  always_ff @(posedge CK) begin
    if (RST)
      dout_q <= '0;
    else if (CS) begin
      if (!WEB)
        dout_q <= DI;
      else
        dout_q <= mem[A];
    end
  end

  assign DO = OE ? dout_q : '0;

endmodule

// File: tb/tb_shab90_4096x16x1cm16.sv
// Directed bench for shab90_4096x16x1cm16: vector table for the corner cases,
// plus full-depth sweeps and a k-means style write/idle/read stream.
module tb_shab90_4096x16x1cm16;

  logic        CK = 1'b0;
  logic        RST;
  logic [11:0] A;
  logic [15:0] DI;
  logic [15:0] DO;
  logic        WEB;
  logic        OE;
  logic        CS;

  int checks = 0;
  int errors = 0;

  shab90_4096x16x1cm16 dut (
    .CK  (CK),
    .RST (RST),
    .A   (A),
    .DI  (DI),
    .DO  (DO),
    .WEB (WEB),
    .OE  (OE),
    .CS  (CS)
  );

  always #5 CK = ~CK;

  typedef struct {
    logic        rst;
    logic        cs;
    logic        web;
    logic        oe;
    logic [11:0] addr;
    logic [15:0] din;
    logic [15:0] expDo;
    string       name;
  } vec_t;

  vec_t vecs [16];

  // Drive one cycle of inputs, then let the rising edge happen and settle.
  task automatic applyStimulus(input logic rst, input logic cs, input logic web,
                               input logic oe, input logic [11:0] addr,
                               input logic [15:0] din);
    RST = rst;
    CS  = cs;
    WEB = web;
    OE  = oe;
    A   = addr;
    DI  = din;
    @(posedge CK);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] expDo);
    checks++;
    if (DO !== expDo) begin
      errors++;
      $display("[TB] FAIL %s: DO=%h expected %h", name, DO, expDo);
    end
  endtask

  function automatic logic [15:0] streamWord(input int i);
    logic [15:0] w;
    w = 16'(i * 40503 + 7);
    return w;
  endfunction

  initial begin
    RST = 1'b1; CS = 1'b0; WEB = 1'b1; OE = 1'b1; A = '0; DI = '0;

    //             rst   cs    web   oe    addr    din       expDo
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 12'd0, 16'h0000, 16'h0000, "resetInit"};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 12'd5, 16'h0505, 16'h0505, "preWrite5"};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 12'd5, 16'hFFFF, 16'h0000, "resetWr1"};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 12'd5, 16'hFFFF, 16'h0000, "resetWr2"};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 12'd5, 16'h0000, 16'h0000, "postResetIdle"};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 12'd5, 16'h0000, 16'h0505, "readAfterReset"};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 12'd3, 16'h00AA, 16'h00AA, "write3"};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 12'd9, 16'h1111, 16'h1111, "write9"};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 12'd3, 16'h5555, 16'h1111, "csLowHold"};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 12'd3, 16'h0000, 16'h00AA, "csLowNoWrite"};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 12'd7, 16'h1234, 16'h1234, "writeThrough7"};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 12'd7, 16'h0000, 16'h1234, "read7"};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 12'd7, 16'hBEEF, 16'hBEEF, "rewrite7"};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 12'd7, 16'h0000, 16'hBEEF, "rawRead7"};
    vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 12'd3, 16'h0000, 16'h0000, "readOeLow"};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b1, 12'd3, 16'h0000, 16'h00AA, "oeHiddenRead"};

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].cs, vecs[i].web, vecs[i].oe,
                    vecs[i].addr, vecs[i].din);
      checkOutput(vecs[i].name, vecs[i].expDo);
    end

    // OE gating is combinational: DO must follow it without a clock edge.
    OE = 1'b0;
    #1;
    checkOutput("oeDropSameCycle", 16'h0000);
    OE = 1'b1;
    #1;
    checkOutput("oeRaiseSameCycle", 16'h00AA);

    // Full-depth sweep: write every address, then read back-to-back.
    for (int i = 0; i < 4096; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 12'(i), 16'(i) ^ 16'hA5A5);
      checkOutput("sweepWriteThrough", 16'(i) ^ 16'hA5A5);
    end
    for (int i = 0; i < 4096; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 12'(i), 16'h0000);
      checkOutput("sweepRead", 16'(i) ^ 16'hA5A5);
    end

    // Mid-stream reset drops the write but keeps the array.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 12'd4095, 16'h0BAD);
    checkOutput("midReset", 16'h0000);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 12'd4095, 16'h0000);
    checkOutput("midResetRetain", 16'd4095 ^ 16'hA5A5);

    // k-means style stream: load all points, idle two cycles, stream them back.
    for (int i = 0; i < 4096; i++)
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 12'(i), streamWord(i));
    checkOutput("streamLastWrite", streamWord(4095));
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 12'd0, 16'h0000);
      checkOutput("streamIdleHold", streamWord(4095));
    end
    for (int i = 0; i < 4096; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 12'(i), 16'h0000);
      checkOutput("streamRead", streamWord(i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
